// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - bus and control signals between the core datapath and the sequencer
interface cpu_sequencer_if;
  logic        waitrequest_i;
  logic        read_i;
  logic        write_i;
  logic [31:0] pc_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [1:0]  state_o;
  logic        active_o;
  logic [31:0] pc_next_o;
  logic        delay_slot_o;
  logic [31:0] cycle_count_o;
  logic [31:0] instr_count_o;

  modport master (
    output waitrequest_i, read_i, write_i, pc_i, jump_i, jump_target_i,
    input  state_o, active_o, pc_next_o, delay_slot_o, cycle_count_o, instr_count_o
  );

  modport slave (
    input  waitrequest_i, read_i, write_i, pc_i, jump_i, jump_target_i,
    output state_o, active_o, pc_next_o, delay_slot_o, cycle_count_o, instr_count_o
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC1/EXEC2 instruction sequencer with delay-slot jumps and halt
module cpu_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pending;
  logic [31:0] r_target;
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  logic        w_stall;
  logic        w_retire;
  logic [31:0] w_pc_next;

  assign w_stall   = (bus.read_i | bus.write_i) & bus.waitrequest_i;
  assign w_retire  = (r_state == EXEC2) && !w_stall;
  // A pending target wins over the sequential PC, so a jump in a delay slot commits the older target first.
  assign w_pc_next = reset     ? RESET_VECTOR :
                     r_pending ? r_target     : bus.pc_i + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    bus.state_o       = r_state;
    bus.active_o      = (r_state != HALT);
    bus.pc_next_o     = w_pc_next;
    bus.delay_slot_o  = r_pending;
    bus.cycle_count_o = r_cycle_count;
    bus.instr_count_o = r_instr_count;
    case (r_state)
      FETCH:   if (!w_stall) w_state_next = EXEC1;
      EXEC1:   if (!w_stall) w_state_next = EXEC2;
      EXEC2:   if (!w_stall) w_state_next = (w_pc_next == HALT_ADDR) ? HALT : FETCH;
      default: w_state_next = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending     <= 1'b0;
      r_target      <= 32'd0;
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      if (r_state != HALT) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 32'd1;
        r_pending     <= bus.jump_i;
        if (bus.jump_i) begin
          r_target <= bus.jump_target_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with directed vectors
module tb_cpu_sequencer;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic        act;
    logic [31:0] pcn;
    logic        ds;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input logic rd, input logic wr, input logic wq,
                       input logic [31:0] pc, input logic j, input logic [31:0] jt);
    bus.read_i        = rd;
    bus.write_i       = wr;
    bus.waitrequest_i = wq;
    bus.pc_i          = pc;
    bus.jump_i        = j;
    bus.jump_target_i = jt;
  endtask

  // Expected outputs for the current cycle; checked by the monitor at the falling edge.
  task automatic step(input string name, input logic [1:0] st, input logic act,
                      input logic [31:0] pcn, input logic ds,
                      input logic [31:0] cyc, input logic [31:0] ins);
    exp_t e;
    e.name = name; e.st = st; e.act = act; e.pcn = pcn;
    e.ds = ds; e.cyc = cyc; e.ins = ins;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if ({bus.state_o, bus.active_o, bus.pc_next_o, bus.delay_slot_o, bus.cycle_count_o, bus.instr_count_o}
          !== {e.st, e.act, e.pcn, e.ds, e.cyc, e.ins}) begin
        fails++;
        $display("FAIL %s: got st=%0d act=%0b pc_next=%h ds=%0b cyc=%0d ins=%0d, expected st=%0d act=%0b pc_next=%h ds=%0b cyc=%0d ins=%0d",
                 e.name, bus.state_o, bus.active_o, bus.pc_next_o, bus.delay_slot_o, bus.cycle_count_o, bus.instr_count_o,
                 e.st, e.act, e.pcn, e.ds, e.cyc, e.ins);
      end
    end
  end

  initial begin
    drive(0, 0, 0, RV, 0, 0);
    @(posedge clk);
    #1;
    step("rst_hold", 0, 1, RV, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) step("free_run", 2'(i % 3), 1, RV + 4, 0, 32'(i), 32'(i / 3));

    drive(1, 0, 1, RV, 0, 0);
    for (int j = 0; j < 4; j++) step("fetch_stall", 0, 1, RV + 4, 0, 32'(9 + j), 3);
    drive(1, 0, 0, RV, 0, 0);
    step("stall_drop", 0, 1, RV + 4, 0, 13, 3);
    drive(0, 0, 1, RV, 0, 0);
    step("wq_ignored", 1, 1, RV + 4, 0, 14, 3);
    drive(0, 0, 0, RV, 0, 0);
    step("stall_e2", 2, 1, RV + 4, 0, 15, 3);

    drive(0, 0, 0, RV + 32'h10, 0, 0);
    step("j_f", 0, 1, RV + 32'h14, 0, 16, 4);
    step("j_e1", 1, 1, RV + 32'h14, 0, 17, 4);
    drive(0, 0, 0, RV + 32'h10, 1, RV + 32'h100);
    step("j_e2", 2, 1, RV + 32'h14, 0, 18, 4);
    drive(0, 0, 0, RV + 32'h14, 0, 0);
    step("ds_f", 0, 1, RV + 32'h100, 1, 19, 5);
    step("ds_e1", 1, 1, RV + 32'h100, 1, 20, 5);
    drive(0, 1, 1, RV + 32'h14, 1, 32'h0DEAD000);
    step("ds_e2_stall0", 2, 1, RV + 32'h100, 1, 21, 5);
    step("ds_e2_stall1", 2, 1, RV + 32'h100, 1, 22, 5);
    drive(0, 1, 0, RV + 32'h14, 0, 0);
    step("ds_e2", 2, 1, RV + 32'h100, 1, 23, 5);
    drive(0, 0, 0, RV + 32'h100, 0, 0);
    step("post_f", 0, 1, RV + 32'h104, 0, 24, 6);
    step("post_e1", 1, 1, RV + 32'h104, 0, 25, 6);
    step("post_e2", 2, 1, RV + 32'h104, 0, 26, 6);

    drive(0, 0, 0, 32'h80, 0, 0);
    step("bb_a_f", 0, 1, 32'h84, 0, 27, 7);
    step("bb_a_e1", 1, 1, 32'h84, 0, 28, 7);
    drive(0, 0, 0, 32'h80, 1, 32'h100);
    step("bb_a_e2", 2, 1, 32'h84, 0, 29, 7);
    drive(0, 0, 0, 32'h84, 0, 0);
    step("bb_ds_f", 0, 1, 32'h100, 1, 30, 8);
    step("bb_ds_e1", 1, 1, 32'h100, 1, 31, 8);
    drive(0, 0, 0, 32'h84, 1, 32'h200);
    step("bb_ds_e2", 2, 1, 32'h100, 1, 32, 8);
    drive(0, 0, 0, 32'h100, 0, 0);
    step("bb_b_f", 0, 1, 32'h200, 1, 33, 9);
    step("bb_b_e1", 1, 1, 32'h200, 1, 34, 9);
    step("bb_b_e2", 2, 1, 32'h200, 1, 35, 9);
    drive(0, 0, 0, 32'h200, 0, 0);
    step("bb_after_f", 0, 1, 32'h204, 0, 36, 10);
    drive(1, 0, 1, 32'h200, 0, 0);
    step("e1_stall", 1, 1, 32'h204, 0, 37, 10);

    reset = 1'b1;
    step("rst_mid_e1", 0, 1, RV, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, RV, 0, 0);
    step("rel_f", 0, 1, RV + 4, 0, 0, 0);
    step("rel_e1", 1, 1, RV + 4, 0, 1, 0);

    drive(0, 0, 0, RV, 1, 32'h0);
    step("jr_e2", 2, 1, RV + 4, 0, 2, 0);
    drive(0, 0, 0, RV + 4, 0, 0);
    step("jr_ds_f", 0, 1, 32'h0, 1, 3, 1);
    step("jr_ds_e1", 1, 1, 32'h0, 1, 4, 1);
    drive(1, 0, 1, RV + 4, 0, 0);
    step("halt_stalled", 2, 1, 32'h0, 1, 5, 1);
    drive(1, 0, 0, RV + 4, 0, 0);
    step("halt_go", 2, 1, 32'h0, 1, 6, 1);
    drive(0, 0, 1, RV + 4, 1, 32'h500);
    for (int k = 0; k < 20; k++) step("halted", 3, 0, RV + 8, 0, 7, 2);

    reset = 1'b1;
    drive(0, 0, 0, RV, 0, 0);
    step("rst_from_halt", 0, 1, RV, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 32'hFFFFFFFC, 0, 0);
    step("wrap_f", 0, 1, 32'h0, 0, 0, 0);
    step("wrap_e1", 1, 1, 32'h0, 0, 1, 0);
    step("wrap_e2", 2, 1, 32'h0, 0, 2, 0);
    step("wrap_halt", 3, 0, 32'h0, 0, 3, 1);

    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Parameters
REQ-001 RESET_VECTOR, 32'hBFC00000, PC value presented on pc_next_o while reset is asserted.
REQ-002 HALT_ADDR, 32'h00000000, committed PC value that halts the core.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 waitrequest_i  input  1  memory bus stall for the current access.
REQ-006 read_i  input  1  memory read requested this cycle (ram_rds from the control decoder).
REQ-007 write_i  input  1  memory write requested this cycle (ram_wen from the control decoder).
REQ-008 pc_i  input  32  current PC register value.
REQ-009 jump_i  input  1  decoded jump/branch taken; sampled only in EXEC2.
REQ-010 jump_target_i  input  32  target address for jump_i.
REQ-011 state_o  output  state_t (2)  encoding FETCH=0, EXEC1=1, EXEC2=2, HALT=3; feeds the control decoder.
REQ-012 active_o  output  1  high while not in HALT.
REQ-013 pc_next_o  output  32  value the PC register loads when pc_wen is asserted.
REQ-014 delay_slot_o  output  1  high while the current instruction is a branch delay slot.
REQ-015 cycle_count_o  output  32  clocks spent while active.
REQ-016 instr_count_o  output  32  instructions retired.

Function
REQ-017 The sequencer SHALL advance FETCH->EXEC1->EXEC2->FETCH, one state per clock, unless stalled.
REQ-018 Stall is defined as (read_i | write_i) & waitrequest_i.
REQ-019 While stalled, the current state, the pending-jump register and instr_count SHALL all hold.
REQ-020 waitrequest_i SHALL be ignored when read_i and write_i are both 0.
REQ-021 A non-stalled EXEC2 SHALL retire one instruction: instr_count increments by 1, wrapping modulo 2^32.
REQ-022 When no jump is pending, pc_next_o SHALL be pc_i + 4, computed modulo 2^32; this output is combinational.
REQ-023 When a jump is pending, pc_next_o SHALL be the stored pending target.
REQ-024 At a non-stalled EXEC2 with jump_i=1, the sequencer SHALL store jump_target_i and set pending for the next instruction (the delay slot).
REQ-025 delay_slot_o SHALL equal the pending flag.
REQ-026 At a non-stalled EXEC2 of a delay-slot instruction, the sequencer SHALL clear pending, unless jump_i=1 in that same EXEC2.
REQ-027 If jump_i=1 in a delay-slot EXEC2, pc_next_o SHALL use the old pending target, and the new target SHALL become pending.
REQ-028 If a retiring EXEC2 has pc_next_o == HALT_ADDR, the next state SHALL be HALT instead of FETCH, and the instruction counts as retired.
REQ-029 HALT SHALL be terminal until reset: state_o, the counters and the pending flag are frozen, and active_o = 0.
REQ-030 A stalled EXEC2 with pc_next_o == HALT_ADDR SHALL NOT halt until the stall clears.
REQ-031 cycle_count SHALL increment on every clock edge while state is not HALT, wrapping modulo 2^32; it increments during stalls too.
REQ-032 The outputs SHALL contain no combinational path from waitrequest_i to state_o.

Reset
REQ-033 Asserting reset SHALL immediately (asynchronously) force: state_o=FETCH, active_o=1, pending=0, delay_slot_o=0, cycle_count_o=0, instr_count_o=0, and pc_next_o=RESET_VECTOR.
REQ-034 Reset asserted mid-instruction or mid-stall SHALL abandon that instruction, and no count SHALL increment.
REQ-035 The first rising clk edge after reset release SHALL move FETCH->EXEC1 when not stalled.

Verification
REQ-036 Free run, waitrequest_i=0, pc_i=32'hBFC00000, no jumps, 3 instructions -> states 0,1,2 repeat; instr_count=3 and cycle_count=9 after 9 clocks; pc_next_o=32'hBFC00004 in EXEC2.
REQ-037 read_i=1 with waitrequest_i=1 for 4 clocks in FETCH -> state_o stays 0 for 4 clocks while cycle_count rises by 4; the state advances to EXEC1 on the clock after waitrequest drops.
REQ-038 Jump at pc_i=32'hBFC00010 to 32'hBFC00100 -> delay_slot_o=1 for the next instruction; that instruction's EXEC2 gives pc_next_o=32'hBFC00100; delay_slot_o=0 afterwards.
REQ-039 jr to 32'h0 followed by a delay slot -> HALT after the delay slot's EXEC2; active_o=0; counters frozen over 20 further clocks.
REQ-040 Back-to-back jumps A->32'h100, then B->32'h200 in the delay slot -> the delay slot commits pc_next_o=32'h100; the next instruction commits 32'h200.
REQ-041 Reset pulse mid-EXEC1, including between clock edges, and from HALT -> immediate FETCH, counters 0, active_o=1, pc_next_o=32'hBFC00000.
